// File: rtl/digit_scan_mux.sv
// digit_scan_mux: time-multiplexed seven-segment scanner with a tear-free per-frame digit snapshot.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits above digit 0.
module digit_scan_mux #(
  parameter  int DIGITS = 8,
  parameter  int NIB_W  = 4,
  parameter  int DIV    = 100000,
  localparam int SEL_W  = $clog2(DIGITS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DIGITS*NIB_W-1:0] data_in,
  input  logic [DIGITS-1:0]       digit_en,
  input  logic                    hold,
  output logic [SEL_W-1:0]        digit_sel,
  output logic [NIB_W-1:0]        digit_val,
  output logic [DIGITS-1:0]       an_n,
  output logic                    blank,
  output logic                    frame_done
);
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0]             cnt;
  logic [SEL_W-1:0]             sel;
  logic [DIGITS-1:0][NIB_W-1:0] snap;
  logic                         load_pend;
  logic                         tick, last, load;
  logic [DIGITS-1:0]            lz;
  logic                         blank_nxt;
  logic [DIGITS-1:0]            an_nxt;

  assign tick = (cnt == CNT_W'(DIV - 1));
  assign last = (sel == SEL_W'(DIGITS - 1));
  // Reload only at the frame wrap so a frame never mixes old and new digits.
  assign load = load_pend | (tick & last & ~hold);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      sel        <= '0;
      snap       <= '0;
      load_pend  <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      cnt        <= tick ? '0 : cnt + CNT_W'(1);
      if (tick) sel <= last ? '0 : sel + SEL_W'(1);
      if (load) snap <= data_in;
      load_pend  <= 1'b0;
      frame_done <= tick & last;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  // zero_up[i]: snapshot digits i..DIGITS-1 are all zero.
  logic [DIGITS:1] zero_up;
  assign zero_up[DIGITS] = 1'b1;
  assign lz[0]           = 1'b0;
  for (genvar i = 1; i < DIGITS; i++) begin : g_lz
    assign zero_up[i] = zero_up[i+1] & (snap[i] == '0);
    assign lz[i]      = zero_up[i];
  end
`else
  assign lz = '0;
`endif

  always_comb begin
    blank_nxt = ~digit_en[sel] | lz[sel];
    an_nxt    = '1;
    if (!blank_nxt) an_nxt[sel] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digit_sel <= '0;
      digit_val <= '0;
      an_n      <= '1;
      blank     <= 1'b1;
    end else begin
      digit_sel <= sel;
      digit_val <= snap[sel];
      an_n      <= an_nxt;
      blank     <= blank_nxt;
    end
  end
endmodule

// File: tb/tb_digit_scan_mux.sv
// Scoreboard bench for digit_scan_mux: expected slots are queued up front, a monitor checks each new slot.
module tb_digit_scan_mux;
  typedef struct packed {
    logic [2:0] sel;
    logic [3:0] val;
    logic [7:0] an;
    logic       blank;
  } slot_t;

  logic        clk = 1'b0, rst = 1'b0, hold = 1'b0;
  logic [31:0] data_in  = '0;
  logic [7:0]  digit_en = 8'hFF;
  logic [2:0]  digit_sel, u1_sel;
  logic [3:0]  digit_val, u1_val;
  logic [7:0]  an_n, u1_an;
  logic        blank, frame_done, u1_blank, u1_fd;

  int    vectors = 0, errors = 0;
  slot_t exp_q[$];
  logic [7:0] an_tab [8];

  digit_scan_mux #(.DIGITS(8), .NIB_W(4), .DIV(4)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .digit_en(digit_en), .hold(hold),
    .digit_sel(digit_sel), .digit_val(digit_val), .an_n(an_n), .blank(blank),
    .frame_done(frame_done));

  digit_scan_mux #(.DIGITS(8), .NIB_W(4), .DIV(1)) dut1 (
    .clk(clk), .rst(rst), .data_in(data_in), .digit_en(digit_en), .hold(hold),
    .digit_sel(u1_sel), .digit_val(u1_val), .an_n(u1_an), .blank(u1_blank),
    .frame_done(u1_fd));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic push_frame(input logic [31:0] d, input logic [7:0] en, input logic [7:0] lzm);
    for (int i = 0; i < 8; i++) begin
      slot_t e;
      logic  bl;
      bl = ~en[i] | lzm[i];
      e  = {3'(i), d[i*4 +: 4], bl ? 8'hFF : an_tab[i], bl};
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_sel(input logic [2:0] s);
    int n = 0;
    do begin @(negedge clk); n++; end while (digit_sel !== s && n < 200);
    if (digit_sel !== s) begin
      vectors++; errors++;
      $display("FAIL wait_sel: timed out, digit_sel=%0d want %0d", digit_sel, s);
    end
  endtask

  task automatic wait_fd();
    int n = 0;
    do begin @(negedge clk); n++; end while (frame_done !== 1'b1 && n < 200);
    if (frame_done !== 1'b1) begin
      vectors++; errors++;
      $display("FAIL wait_fd: timed out, frame_done=%b want 1", frame_done);
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 400) begin @(negedge clk); n++; end
    vectors++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d slots pending, want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic enter_rst();
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic leave_rst();
    @(negedge clk); rst = 1'b0;
  endtask

  // Monitor: a new slot shows up as a change of digit_sel or an_n; sample its second cycle.
  logic [2:0] prev_sel = '0;
  logic [7:0] prev_an  = 8'hFF;
  bit         pend     = 1'b0;
  always @(negedge clk) begin
    slot_t e, a;
    if (rst) begin
      prev_sel = '0; prev_an = 8'hFF; pend = 1'b0;
    end else begin
      if (pend && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {digit_sel, digit_val, an_n, blank};
        vectors++;
        if (a !== e) begin
          errors++;
          $display("FAIL slot%0d: got sel=%0d val=%h an_n=%h blank=%b, want sel=%0d val=%h an_n=%h blank=%b",
                   e.sel, a.sel, a.val, a.an, a.blank, e.sel, e.val, e.an, e.blank);
        end
      end
      pend     = (digit_sel != prev_sel) || (an_n != prev_an);
      prev_sel = digit_sel;
      prev_an  = an_n;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
    $fatal(1, "watchdog");
  end

  initial begin
    int fd_cnt, dbl;
    bit fd_prev;
    an_tab = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
    rst = 1'b1;
    data_in = 32'h1234_5678; digit_en = 8'hFF; hold = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_an_n",  an_n, 8'hFF);
    check("rst_blank", 8'(blank), 8'd1);
    check("rst_val",   8'(digit_val), 8'd0);
    check("rst_sel",   8'(digit_sel), 8'd0);
    check("rst_fd",    8'(frame_done), 8'd0);
    check("rst_u1_an", u1_an, 8'hFF);

    // Startup and scan order over two frames, frame_done cadence over 96 clks.
    push_frame(32'h1234_5678, 8'hFF, 8'h00);
    push_frame(32'h1234_5678, 8'hFF, 8'h00);
    rst = 1'b0;
    fd_cnt = 0; dbl = 0; fd_prev = 1'b0;
    for (int k = 1; k <= 96; k++) begin
      @(negedge clk);
      if (k == 2) begin
        check("start_an_n", an_n, 8'hFE);
        check("start_val",  8'(digit_val), 8'h08);
      end
      if (frame_done) fd_cnt++;
      if (frame_done && fd_prev) dbl++;
      fd_prev = frame_done;
    end
    check("fd_count", 8'(fd_cnt), 8'd3);
    check("fd_width", 8'(dbl), 8'd0);
    wait_drain();

    // Hold keeps the snapshot; unheld mid-frame change waits for the frame wrap.
    enter_rst();
    data_in = 32'h1234_5678; hold = 1'b0;
    push_frame(32'h1234_5678, 8'hFF, 8'h00);
    push_frame(32'h1234_5678, 8'hFF, 8'h00);
    push_frame(32'hFFFF_FFFF, 8'hFF, 8'h00);
    push_frame(32'hA5A5_A5A5, 8'hFF, 8'h00);
    leave_rst();
    wait_sel(3'd3); data_in = 32'hFFFF_FFFF; hold = 1'b1;
    wait_fd(); wait_sel(3'd3); hold = 1'b0;
    wait_fd(); wait_sel(3'd3); data_in = 32'hA5A5_A5A5;
    wait_drain();

    // Enable mask.
    enter_rst();
    data_in = 32'h1234_5678; digit_en = 8'h0F;
    push_frame(32'h1234_5678, 8'h0F, 8'h00);
    leave_rst();
    wait_drain();

    // Leading-zero blanking.
    enter_rst();
    data_in = 32'h0000_0042; digit_en = 8'hFF;
`ifdef LEADING_ZERO_BLANK_EN
    push_frame(32'h0000_0042, 8'hFF, 8'hFC);
`else
    push_frame(32'h0000_0042, 8'hFF, 8'h00);
`endif
    leave_rst();
    wait_drain();
    enter_rst();
    data_in = 32'h0000_0000;
`ifdef LEADING_ZERO_BLANK_EN
    push_frame(32'h0000_0000, 8'hFF, 8'hFE);
`else
    push_frame(32'h0000_0000, 8'hFF, 8'h00);
`endif
    leave_rst();
    wait_drain();

    // Asynchronous reset mid-scan, then DIV=1 stepping and scan restart.
    enter_rst();
    data_in = 32'h1234_5678;
    leave_rst();
    wait_sel(3'd5);
    #1 rst = 1'b1;
    #1;
    check("async_an_n",  an_n, 8'hFF);
    check("async_sel",   8'(digit_sel), 8'd0);
    check("async_blank", 8'(blank), 8'd1);
    check("async_val",   8'(digit_val), 8'd0);
    @(negedge clk);
    push_frame(32'h1234_5678, 8'hFF, 8'h00);
    @(negedge clk); rst = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      check($sformatf("div1_sel%0d", k), 8'(u1_sel), 8'((k - 1) % 8));
      check($sformatf("div1_an%0d", k),  u1_an, an_tab[(k - 1) % 8]);
      if (k >= 2) check($sformatf("div1_val%0d", k), 8'(u1_val), 8'(8 - ((k - 1) % 8)));
      if (k == 7) check("div1_fd7", 8'(u1_fd), 8'd0);
      if (k == 8) check("div1_fd8", 8'(u1_fd), 8'd1);
    end
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
